// File: rtl/uart_bit_sequencer.sv
// UART frame bit sequencer.
// Walks one frame through START, DATA, optional PARITY and one or two STOP bits. It is paced
// by an oversample enable, and OVERSAMPLE ticks make one bit.
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   tick              oversample enable; all counters advance only when high
//   start             frame request, honoured in IDLE only
//   abort             cancel the current frame, return to IDLE
//   cfg_data_bits     data bits per frame (5..MAX_DATA_BITS), latched at start
//   cfg_parity_en     one parity bit after the data, latched at start
//   cfg_stop2         two stop bits instead of one, latched at start
//   busy              high whenever the sequencer is not IDLE
//   state             IDLE=0 START=1 DATA=2 PARITY=3 STOP=4 DONE=5
//   bit_index         current data bit (0-based); 0 outside DATA
//   sample_strobe     one-cycle pulse at mid-bit
//   bit_strobe        one-cycle pulse at end of each bit
//   frame_done        one-cycle pulse when a frame completes
//   cfg_err           one-cycle pulse when a start is rejected for bad cfg_data_bits
module uart_bit_sequencer #(
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned MAX_DATA_BITS = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_stop2,
  output logic       busy,
  output logic [2:0] state,
  output logic [3:0] bit_index,
  output logic       sample_strobe,
  output logic       bit_strobe,
  output logic       frame_done,
  output logic       cfg_err
);

  localparam int unsigned     CntW    = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [3:0]      MaxBits = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic [3:0]      data_bits_q, data_bits_d;
  logic            parity_q, parity_d;
  logic            stop2_q, stop2_d;
  logic            sample_q, sample_d;
  logic            bit_q, bit_d;
  logic            cfg_err_q, cfg_err_d;

  logic cfg_legal;
  logic end_of_bit;

  assign cfg_legal  = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= MaxBits);
  assign end_of_bit = tick && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    data_bits_d = data_bits_q;
    parity_d    = parity_q;
    stop2_d     = stop2_q;
    sample_d    = 1'b0;
    bit_d       = 1'b0;
    cfg_err_d   = 1'b0;

    if (abort && (state_q != StIdle)) begin
      // Cancel drops everything in flight; no strobes, no frame_done.
      state_d    = StIdle;
      cnt_d      = '0;
      bit_idx_d  = '0;
      stop_cnt_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_legal) begin
              data_bits_d = cfg_data_bits;
              parity_d    = cfg_parity_en;
              stop2_d     = cfg_stop2;
              cnt_d       = '0;
              bit_idx_d   = '0;
              stop_cnt_d  = 1'b0;
              state_d     = StStart;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end

        // DONE is the one state that moves without a tick.
        StDone: state_d = StIdle;

        StStart, StData, StParity, StStop: begin
          if (tick) begin
            cnt_d    = end_of_bit ? '0 : cnt_q + CntOne;
            sample_d = (cnt_q == CntMid);
            bit_d    = end_of_bit;
          end
          if (end_of_bit) begin
            case (state_q)
              StStart: begin
                state_d   = StData;
                bit_idx_d = '0;
              end
              StData: begin
                if (bit_idx_q == data_bits_q - 4'd1) begin
                  bit_idx_d = '0;
                  state_d   = parity_q ? StParity : StStop;
                end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                end
              end
              StParity: state_d = StStop;
              default: begin
                // StStop: stop_cnt marks that the first of two stop bits is done.
                if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
                end else begin
                  stop_cnt_d = 1'b0;
                  state_d    = StDone;
                end
              end
            endcase
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      data_bits_q <= '0;
      parity_q    <= 1'b0;
      stop2_q     <= 1'b0;
      sample_q    <= 1'b0;
      bit_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      data_bits_q <= data_bits_d;
      parity_q    <= parity_d;
      stop2_q     <= stop2_d;
      sample_q    <= sample_d;
      bit_q       <= bit_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign state         = state_q;
  assign bit_index     = bit_idx_q;
  assign sample_strobe = sample_q;
  assign bit_strobe    = bit_q;
  assign frame_done    = (state_q == StDone);
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_uart_bit_sequencer.sv
// Directed bench for uart_bit_sequencer (OVERSAMPLE=16, MAX_DATA_BITS=9).
// Outputs are observed and inputs driven on the falling clock edge.
module tb_uart_bit_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic       abort;
  logic [3:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_stop2;
  logic       busy;
  logic [2:0] state;
  logic [3:0] bit_index;
  logic       sample_strobe;
  logic       bit_strobe;
  logic       frame_done;
  logic       cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  uart_bit_sequencer #(
    .OVERSAMPLE   (16),
    .MAX_DATA_BITS(9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .abort        (abort),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity_en(cfg_parity_en),
    .cfg_stop2    (cfg_stop2),
    .busy         (busy),
    .state        (state),
    .bit_index    (bit_index),
    .sample_strobe(sample_strobe),
    .bit_strobe   (bit_strobe),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_quiet(input string tag);
    check({tag, ".state"}, 32'(state), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".bit_index"}, 32'(bit_index), 32'd0);
    check({tag, ".strobes"}, {29'd0, sample_strobe, bit_strobe, frame_done}, 32'd0);
  endtask

  // Drive a start at the current falling edge and step one cycle.
  task automatic start_frame(input logic [3:0] nb, input logic par, input logic st2);
    cfg_data_bits = nb;
    cfg_parity_en = par;
    cfg_stop2     = st2;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one whole frame. Tick is high in cycles where k % per == 0 (k=1 is the first START
  // cycle). At cycle mut_k (if non-zero) the cfg inputs change and start is pulsed.
  task automatic run_frame(input string tag, input logic [3:0] nb, input logic par,
                           input logic st2, input int per, input int mut_k);
    int          nbits;
    int          n_bit;
    int          n_smp;
    int          n_par;
    int          n_bad;
    int          n_tick;
    int          done_k;
    logic [15:0] mask;
    logic [2:0]  prev_state;
    logic        prev_tick;
    nbits  = 1 + int'(nb) + int'(par) + (st2 ? 2 : 1);
    n_bit  = 0;
    n_smp  = 0;
    n_par  = 0;
    n_bad  = 0;
    n_tick = 0;
    done_k = 0;
    mask   = '0;
    tick   = 1'b0;
    start_frame(nb, par, st2);
    check({tag, ".accept"}, 32'(state), 32'd1);
    prev_state = 3'd1;
    prev_tick  = 1'b0;
    for (int k = 1; k <= 1500; k++) begin
      if (bit_strobe) begin
        n_bit++;
        if (!prev_tick) n_bad++;
      end
      if (sample_strobe) begin
        n_smp++;
        if (!prev_tick) n_bad++;
      end
      if (state == 3'd2) mask[bit_index] = 1'b1;
      if (state == 3'd3 && prev_state != 3'd3) n_par++;
      if (frame_done) begin
        done_k = k;
        break;
      end
      prev_state = state;
      if (k == mut_k) begin
        cfg_data_bits = 4'd5;
        cfg_parity_en = ~par;
        cfg_stop2     = ~st2;
        start         = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick = ((k % per) == 0);
      if (tick) n_tick++;
      prev_tick = tick;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(done_k != 0), 32'd1);
    check({tag, ".ticks_to_done"}, 32'(n_tick), 32'(16 * nbits));
    if (per == 1) check({tag, ".cycles_to_done"}, 32'(done_k), 32'(16 * nbits + 1));
    check({tag, ".bit_strobes"}, 32'(n_bit), 32'(nbits));
    check({tag, ".sample_strobes"}, 32'(n_smp), 32'(nbits));
    check({tag, ".data_bit_indices"}, 32'(mask), (32'd1 << nb) - 32'd1);
    check({tag, ".parity_entries"}, 32'(n_par), 32'(par));
    check({tag, ".strobe_without_tick"}, 32'(n_bad), 32'd0);
    tick = 1'b1;
    @(negedge clk);
    check_idle_quiet({tag, ".after_done"});
  endtask

  initial begin
    rst           = 1'b1;
    tick          = 1'b1;
    start         = 1'b1;
    abort         = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_parity_en = 1'b0;
    cfg_stop2     = 1'b0;

    // Reset held with start high: nothing may move.
    repeat (3) @(negedge clk);
    check_idle_quiet("reset");
    check("reset.cfg_err", 32'(cfg_err), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // 8N1, tick every cycle.
    run_frame("8n1", 4'd8, 1'b0, 1'b0, 1, 0);

    // 9 data bits, parity, two stops, tick every 4th cycle.
    run_frame("9p2_sparse", 4'd9, 1'b1, 1'b1, 4, 0);

    // Illegal data-bit counts are rejected with a single cfg_err pulse.
    tick = 1'b1;
    start_frame(4'd4, 1'b0, 1'b0);
    check("cfg4.err", 32'(cfg_err), 32'd1);
    check_idle_quiet("cfg4");
    @(negedge clk);
    check("cfg4.err_clear", 32'(cfg_err), 32'd0);
    check_idle_quiet("cfg4.next");
    start_frame(4'd10, 1'b1, 1'b1);
    check("cfg10.err", 32'(cfg_err), 32'd1);
    check_idle_quiet("cfg10");
    @(negedge clk);
    check("cfg10.err_clear", 32'(cfg_err), 32'd0);

    // Smallest legal frame.
    run_frame("5n1", 4'd5, 1'b0, 1'b0, 1, 0);

    // Abort on the end-of-bit tick of data bit 3 (cycle 80).
    tick = 1'b1;
    start_frame(4'd8, 1'b0, 1'b0);
    repeat (79) @(negedge clk);
    check("abort.pre_state", 32'(state), 32'd2);
    check("abort.pre_index", 32'(bit_index), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_quiet("abort");
    @(negedge clk);
    check_idle_quiet("abort.next");
    run_frame("after_abort", 4'd8, 1'b0, 1'b0, 1, 0);

    // Reset during the stop bit (cycle 150), then immediate restart.
    tick = 1'b1;
    start_frame(4'd8, 1'b0, 1'b0);
    repeat (149) @(negedge clk);
    check("rst_stop.pre_state", 32'(state), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_quiet("rst_stop");
    check("rst_stop.cfg_err", 32'(cfg_err), 32'd0);
    run_frame("after_rst", 4'd8, 1'b0, 1'b0, 1, 0);

    // cfg change plus stray start in DATA must not disturb the running frame.
    run_frame("cfg_mid", 4'd8, 1'b0, 1'b0, 1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bit_sequencer.md
UART_BIT_SEQUENCER -- requirements
Module: uart_bit_sequencer

Interface
REQ-001 Parameter OVERSAMPLE, default 16, ticks per bit; even, >= 4.
REQ-002 Parameter MAX_DATA_BITS, default 9, largest legal data-bit count.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  oversample enable; counters advance only in cycles where tick=1.
REQ-006 start  input  1  frame request; sampled in IDLE only.
REQ-007 abort  input  1  synchronous frame cancel.
REQ-008 cfg_data_bits  input  4  data bits per frame; legal range 5..MAX_DATA_BITS.
REQ-009 cfg_parity_en  input  1  1 = one parity bit after data.
REQ-010 cfg_stop2  input  1  1 = two stop bits, 0 = one.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 state  output  3  IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, DONE=5.
REQ-013 bit_index  output  4  current data bit, 0-based; 0 outside DATA.
REQ-014 sample_strobe  output  1  one-cycle pulse at mid-bit.
REQ-015 bit_strobe  output  1  one-cycle pulse at end of each bit.
REQ-016 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-017 cfg_err  output  1  one-cycle pulse when start is rejected for an illegal configuration.

Function
REQ-018 In IDLE, start=1 with legal cfg_data_bits shall latch all three cfg inputs and move to START next cycle; cfg input changes after that shall have no effect until the next IDLE.
REQ-019 In IDLE, start=1 with cfg_data_bits outside 5..MAX_DATA_BITS shall pulse cfg_err next cycle and remain in IDLE.
REQ-020 start in any state other than IDLE shall be ignored.
REQ-021 The tick counter shall reset to 0 on entry to START and count 0..OVERSAMPLE-1 on tick cycles, then wrap to 0.
REQ-022 A tick at count OVERSAMPLE/2-1 shall produce sample_strobe in the following cycle.
REQ-023 A tick at count OVERSAMPLE-1 shall produce bit_strobe in the following cycle, and the bit/state update shall take effect in that same cycle.
REQ-024 Transitions shall occur on the end-of-bit tick:
  - START -> DATA.
  - DATA: increment bit_index; after bit latched_N-1, go to PARITY if parity is enabled, else STOP.
  - PARITY -> STOP.
  - STOP: after one bit, or after two if cfg_stop2 was latched, go to DONE.
REQ-025 DONE shall last exactly one cycle with frame_done=1, then return to IDLE; start is ignored in DONE.
REQ-026 Total frame length shall be OVERSAMPLE*(1+N+P+S) tick cycles, where N is the data-bit count, P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
REQ-027 Cycles with tick=0 shall freeze all counters and the state (except DONE -> IDLE); strobes shall stay low.
REQ-028 abort=1 shall force IDLE next cycle and zero the tick counter, bit_index and stop counter, with no frame_done and no strobes.
REQ-029 abort in IDLE shall have no effect.
REQ-030 Priority within a cycle shall be rst > abort > tick-driven progression > start.
REQ-031 bit_index shall never exceed latched_N-1; no counter shall wrap outside its defined range.

Reset
REQ-032 rst=1 at a clock edge shall set:
  - state=IDLE.
  - all counters and latched configuration to 0.
  - busy, sample_strobe, bit_strobe, frame_done and cfg_err to 0.
REQ-033 Reset shall behave identically mid-frame: no frame_done, and no strobe in the cycle after rst.
REQ-034 With rst held high, start shall be ignored.

Verification
REQ-035 OVERSAMPLE=16, 8N1, tick=1 every cycle, one start pulse -> exactly 10 bit_strobe and 10 sample_strobe pulses, bit_index 0..7 in DATA, one frame_done 161 cycles after start.
REQ-036 9 data bits with parity, 2 stop bits, tick every 4th cycle -> 13 bit_strobe pulses, the PARITY state seen once, frame_done after 13*16 ticks.
REQ-037 cfg_data_bits=4, then 10, with start -> one cfg_err pulse each time, busy stays 0, no strobes.
REQ-038 abort at bit_index=3 in the same cycle as an end-of-bit tick -> IDLE next cycle, bit_index=0, no bit_strobe, no frame_done; a new start then runs a full frame normally.
REQ-039 rst asserted during STOP -> all outputs 0 the next cycle, then a start in the following cycle is accepted.
REQ-040 Change cfg_data_bits from 8 to 5 mid-frame and pulse start during DATA -> the frame still carries 8 data bits and the start is ignored.
